// File: rtl/call_driver.sv
// call_driver: accepts a request, launches one call on a multi-cycle callee,
// waits for completion or a timeout, and then returns a registered response
// to the downstream side.
module call_driver #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        call_start,
    output logic [31:0] call_a,
    output logic [31:0] call_b,
    input  logic [31:0] call_result,
    input  logic        call_done,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [7:0]  timeout_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // TIMEOUT == 0 turns the watchdog off entirely.
    localparam bit          LP_TO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] LP_TO_LAST = LP_TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

    state_t      r_state;
    logic [15:0] r_wait_cnt;
    logic        r_call_start;
    logic [31:0] r_call_a;
    logic [31:0] r_call_b;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_result;
    logic        r_rsp_timeout;
    logic        r_busy;
    logic [7:0]  r_timeout_count;

    logic        w_idle;
    logic        w_hs;
    logic        w_expire;

    // The counter holds (WAIT cycles already completed), so the last allowed
    // WAIT cycle is the one where it equals TIMEOUT-1.
    assign w_idle   = (r_state == S_IDLE);
    assign w_hs     = req_valid & w_idle;
    assign w_expire = LP_TO_EN && (r_wait_cnt == LP_TO_LAST);

    // req_ready is the only combinational output: it decodes the state register.
    assign req_ready     = w_idle;
    assign call_start    = r_call_start;
    assign call_a        = r_call_a;
    assign call_b        = r_call_b;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_result    = r_rsp_result;
    assign rsp_timeout   = r_rsp_timeout;
    assign busy          = r_busy;
    assign timeout_count = r_timeout_count;

    // Call sequencing FSM with all handshake outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_wait_cnt      <= 16'd0;
            r_call_start    <= 1'b0;
            r_call_a        <= 32'd0;
            r_call_b        <= 32'd0;
            r_rsp_valid     <= 1'b0;
            r_rsp_result    <= 32'd0;
            r_rsp_timeout   <= 1'b0;
            r_busy          <= 1'b0;
            r_timeout_count <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // call_done is deliberately not looked at here.
                    if (w_hs) begin
                        r_call_a     <= req_a;
                        r_call_b     <= req_b;
                        r_call_start <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // One-cycle start strobe; a done that is already high is
                    // stale and only counts once we are in WAIT.
                    r_call_start <= 1'b0;
                    r_wait_cnt   <= 16'd0;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 16'd1;
                    // Completion is checked first so it beats a same-cycle expiry.
                    if (call_done) begin
                        r_rsp_result  <= call_result;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else if (w_expire) begin
                        r_rsp_result  <= 32'd0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        if (r_timeout_count != 8'hFF) begin
                            r_timeout_count <= r_timeout_count + 8'd1;
                        end
                        r_state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Going back through IDLE means req_ready rises one cycle
                    // after the response is taken, never on the same edge.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_call_driver.sv
// tb_call_driver: random and directed calls against call_driver with a
// scoreboard; a behavioural callee answers after a chosen number of WAIT
// cycles and the expected response is derived from that choice.
module tb_call_driver;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        call_start;
    logic [31:0] call_a;
    logic [31:0] call_b;
    logic [31:0] call_result = 32'd0;
    logic        call_done = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_timeout;
    logic        busy;
    logic [7:0]  timeout_count;

    call_driver #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .call_start(call_start), .call_a(call_a), .call_b(call_b),
        .call_result(call_result), .call_done(call_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
        .busy(busy), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } issue_t;

    typedef struct {
        int          d;
        logic [31:0] r;
    } callee_t;

    typedef struct {
        logic [31:0] res;
        logic        to;
        logic [7:0]  tc;
        int          cyc;
    } exp_t;

    issue_t  issue_q[$];
    callee_t callee_q[$];
    exp_t    exp_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          model_tc = 0;
    bit          bp_hold = 1'b0;
    bit          stale_on = 1'b0;
    logic [31:0] stale_res = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", nm, what, cyc);
    endtask

    // Downstream: random acceptance unless backpressure is being forced.
    always @(posedge clk) begin
        #1;
        rsp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Callee: answers on WAIT cycle d+1 when d < TMO, otherwise stays silent.
    // In stale mode it holds done high regardless of the call sequence.
    initial begin
        callee_t c;
        forever begin
            @(negedge clk);
            if (stale_on) begin
                call_done   = 1'b1;
                call_result = stale_res;
            end else begin
                call_done = 1'b0;
                if (call_start && callee_q.size() > 0) begin
                    c = callee_q.pop_front();
                    if (c.d < TMO) begin
                        repeat (c.d + 1) @(negedge clk);
                        call_done   = 1'b1;
                        call_result = c.r;
                        @(negedge clk);
                        call_done   = 1'b0;
                        call_result = $urandom;
                    end
                end
            end
        end
    end

    // Monitor: pops expectations as the DUT presents calls and responses.
    logic        prev_start = 1'b0;
    logic        seen = 1'b0;
    logic [31:0] held_a = 32'd0, held_b = 32'd0, held_res = 32'd0;
    logic        held_to = 1'b0;
    initial begin
        issue_t is;
        exp_t   e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (call_start) begin
                    chk("start_single_pulse", 32'(prev_start), 32'd0);
                    if (issue_q.size() == 0) begin
                        fail_now("call_unexpected", "call_start=1 required no pending request");
                    end else begin
                        is = issue_q.pop_front();
                        chk("call_a", call_a, is.a);
                        chk("call_b", call_b, is.b);
                    end
                    held_a = call_a;
                    held_b = call_b;
                end else if (busy) begin
                    chk("call_a_stable", call_a, held_a);
                    chk("call_b_stable", call_b, held_b);
                end
                if (rsp_valid) begin
                    chk("req_ready_in_resp", 32'(req_ready), 32'd0);
                    if (!seen) begin
                        seen = 1'b1;
                        held_res = rsp_result;
                        held_to  = rsp_timeout;
                        if (exp_q.size() == 0) begin
                            fail_now("rsp_unexpected", "rsp_valid=1 required no pending response");
                        end else begin
                            e = exp_q.pop_front();
                            chk("rsp_result", rsp_result, e.res);
                            chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                            chk("timeout_count", 32'(timeout_count), 32'(e.tc));
                            chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                        end
                    end else begin
                        chk("rsp_result_stable", rsp_result, held_res);
                        chk("rsp_timeout_stable", 32'(rsp_timeout), 32'(held_to));
                    end
                end else begin
                    seen = 1'b0;
                end
                prev_start = call_start;
            end else begin
                prev_start = 1'b0;
                seen = 1'b0;
            end
        end
    end

    // Issue one request; expectations are computed from the callee delay d.
    task automatic do_req(input logic [31:0] a, input logic [31:0] b, input int d,
                          input logic [31:0] r, input bit use_callee);
        int k;
        bit ok;
        exp_t e;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail_now("req_accept", "no handshake within 400 cycles");
            req_valid = 1'b0;
            return;
        end
        k = cyc + 1;  // cycle number of ISSUE
        issue_q.push_back('{a: a, b: b});
        if (use_callee) callee_q.push_back('{d: d, r: r});
        if (d < TMO) begin
            e.res = r;
            e.to  = 1'b0;
            e.cyc = k + 2 + d;
        end else begin
            e.res = 32'd0;
            e.to  = 1'b1;
            if (model_tc < 255) model_tc++;
            e.cyc = k + 1 + TMO;
        end
        e.tc = 8'(model_tc);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a = $urandom;
        req_b = $urandom;
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now(nm, "response not drained within 500 cycles");
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_call_start"}, 32'(call_start), 32'd0);
        chk({nm, "_call_a"}, call_a, 32'd0);
        chk({nm, "_call_b"}, call_b, 32'd0);
        chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({nm, "_rsp_result"}, rsp_result, 32'd0);
        chk({nm, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_timeout_count"}, 32'(timeout_count), 32'd0);
        chk({nm, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        fail_now("watchdog", "simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        // Reset values while reset is held, with a request already pending.
        req_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;

        // Basic call: done two cycles after start.
        do_req(32'd5, 32'd9, 1, 32'd5, 1'b1);
        wait_idle("basic");
        // Done on the last WAIT cycle beats the timeout.
        do_req(32'd1, 32'd2, TMO - 1, 32'hDEAD, 1'b1);
        wait_idle("simultaneous");
        // No done at all: timeout response.
        do_req(32'd3, 32'd4, TMO + 1, 32'h1234, 1'b1);
        wait_idle("timeout");

        // Stale done held through IDLE and ISSUE completes on the first WAIT cycle.
        stale_res = 32'hCAFE0001;
        stale_on = 1'b1;
        repeat (2) @(posedge clk);
        do_req(32'd11, 32'd12, 0, 32'hCAFE0001, 1'b0);
        wait_idle("stale");
        stale_on = 1'b0;
        @(negedge clk);

        // Backpressure: response held for 10 cycles while a second request waits.
        bp_hold = 1'b1;
        do_req(32'd7, 32'd8, 0, 32'h77, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("bp_rsp", "rsp_valid not seen within 20 cycles");
        fork
            begin
                repeat (9) @(negedge clk);
                chk("bp_rsp_held", 32'(rsp_valid), 32'd1);
                chk("bp_no_accept", 32'(issue_q.size()), 32'd0);
                @(posedge clk);
                #2;
                bp_hold = 1'b0;
            end
        join_none
        do_req(32'd10, 32'd20, 2, 32'h99, 1'b1);
        wait_idle("backpressure");

        // Reset pulsed in WAIT abandons the call without a response.
        do_req(32'd21, 32'd22, TMO + 1, 32'd0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        callee_q.delete();
        model_tc = 0;
        @(negedge clk);
        check_reset("midrst");
        repeat (6) @(negedge clk);
        chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);

        // Random calls over all delays, including the expiry boundary.
        for (int i = 0; i < 40; i++) begin
            do_req($urandom, $urandom, int'($urandom_range(0, TMO + 1)), $urandom, 1'b1);
        end
        wait_idle("random");

        // Drive enough timeouts to reach saturation of timeout_count.
        for (int i = 0; i < 260; i++) begin
            do_req($urandom, $urandom, TMO + 1, 32'd0, 1'b1);
        end
        wait_idle("saturate");
        chk("tc_saturated", 32'(timeout_count), 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/call_driver.md
CALL_DRIVER -- requirements
Module: call_driver

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255; the number of WAIT cycles without call_done before the call is abandoned; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1 bit; the single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port req_valid, input, 1 bit; an upstream request is present.
REQ-005 SHALL have port req_ready, output, 1 bit; the block accepts a request this cycle.
REQ-006 SHALL have port req_a, input, 32 bits; operand a of the request.
REQ-007 SHALL have port req_b, input, 32 bits; operand b of the request.
REQ-008 SHALL have port call_start, output, 1 bit; start strobe to the callee.
REQ-009 SHALL have port call_a, output, 32 bits; operand a presented to the callee.
REQ-010 SHALL have port call_b, output, 32 bits; operand b presented to the callee.
REQ-011 SHALL have port call_result, input, 32 bits; result from the callee.
REQ-012 SHALL have port call_done, input, 1 bit; the callee's completion flag.
REQ-013 SHALL have port rsp_valid, output, 1 bit; a response is pending.
REQ-014 SHALL have port rsp_ready, input, 1 bit; downstream accepts the response.
REQ-015 SHALL have port rsp_result, output, 32 bits; the captured result.
REQ-016 SHALL have port rsp_timeout, output, 1 bit; the response is from an abandoned call.
REQ-017 SHALL have port busy, output, 1 bit; the state is not IDLE.
REQ-018 SHALL have port timeout_count, output, 8 bits; saturating count of timed-out calls.

Function
REQ-019 SHALL implement the states IDLE, ISSUE, WAIT and RESP, with all outputs registered except req_ready.
REQ-020 SHALL drive req_ready = 1 only in IDLE; a handshake occurs when req_valid and req_ready are both 1 on a rising edge.
REQ-021 SHALL, on a handshake in cycle k, register req_a and req_b into call_a and call_b and enter ISSUE in cycle k+1.
REQ-022 SHALL drive call_start = 1 for exactly the one ISSUE cycle, then enter WAIT.
REQ-023 SHALL hold call_a and call_b stable from ISSUE until the next handshake.
REQ-024 SHALL clear the wait counter on entry to WAIT and increment it once per WAIT cycle, with a counter width of 16 bits so it is sufficient for TIMEOUT.
REQ-025 SHALL ignore call_done in IDLE, ISSUE and RESP; a stale done from an earlier call SHALL NOT complete a new call.
REQ-026 SHALL, when call_done = 1 in WAIT, capture call_result into rsp_result, clear rsp_timeout and enter RESP on the next edge.
REQ-027 SHALL, when TIMEOUT != 0 and TIMEOUT WAIT cycles elapse without call_done, set rsp_result = 0, set rsp_timeout = 1, increment timeout_count saturating at 255, and enter RESP.
REQ-028 SHALL let completion win when call_done and timeout expiry occur in the same cycle: no timeout is recorded.
REQ-029 SHALL hold rsp_valid = 1 throughout RESP with rsp_result and rsp_timeout stable until rsp_ready = 1.
REQ-030 SHALL, on rsp_valid & rsp_ready, return to IDLE; req_ready rises the following cycle, so there is no same-cycle re-accept.
REQ-031 SHALL give a minimum request-to-response latency of 3 cycles: handshake at k, call_start at k+1, done sampled at k+2, rsp_valid at k+3.
REQ-032 SHALL drive busy = 1 in ISSUE, WAIT and RESP.

Reset
REQ-033 SHALL, while rst = 1, force state IDLE, call_start = 0, call_a = 0, call_b = 0, rsp_valid = 0, rsp_result = 0, rsp_timeout = 0, timeout_count = 0 and wait counter = 0.
REQ-034 SHALL, on rst asserted mid-call in any state, abandon the call with no response and no timeout_count change, and accept requests in the first cycle after rst deasserts.
REQ-035 SHALL take reset priority over every other input in the same cycle.

Verification
REQ-036 SHALL cover a basic call: req a=5, b=9; callee asserts done with result=5 two cycles after start -> exactly one call_start pulse, call_a=5 and call_b=9 stable, rsp_result=5 and rsp_timeout=0.
REQ-037 SHALL cover backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_result held constant, req_ready=0, and a second req_valid is not accepted.
REQ-038 SHALL cover timeout: TIMEOUT=4 and call_done never asserted -> rsp_valid 4 WAIT cycles after entry, rsp_result=0, rsp_timeout=1, timeout_count=1.
REQ-039 SHALL cover the simultaneous event: TIMEOUT=4 with call_done on the 4th WAIT cycle, result=0xDEAD -> rsp_result=0xDEAD, rsp_timeout=0, timeout_count unchanged.
REQ-040 SHALL cover a stale done: call_done held 1 through IDLE and ISSUE -> no completion before WAIT, and completion on the first WAIT cycle only.
REQ-041 SHALL cover reset mid-call: rst pulsed in WAIT -> all outputs at reset values the next cycle, no rsp_valid, and req_ready=1 after deassertion.
